tim_dp: RTL and testbench
=========================

# tim_dp

Dual-port, banked tightly integrated memory: the next generation of the single-port TIM. It has an instruction fetch port and a data load/store port, each with its own grant/ready handshake. Bank count, bank depth and base address are parameters. Both ports are served in the same cycle when they hit different banks. Same-bank conflicts use starvation-free arbitration, writes use native byte enables with no read-modify-write, and accesses outside the window return an error. It sits between the core's fetch/LSU and the bus, in place of the single-port TIM.

## Interface
- tim_width, default 4: number of banks; power of two, ≥2. bw = log2(tim_width).
- tim_depth, default 1024: 32-bit words per bank; power of two. dw = log2(tim_depth).
- tim_base, default 32'h0: byte base address; aligned to window size tim_width*tim_depth*4.

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low.
- itim_valid  in  1: fetch request.
- itim_addr  in  32: fetch byte address (bits [1:0] ignored).
- itim_gnt  out  1: fetch request accepted this cycle (combinational).
- itim_rdata  out  32: fetch data.
- itim_error  out  1: fetch response is an error.
- itim_ready  out  1: fetch response valid.
- dtim_valid  in  1: data request.
- dtim_addr  in  32: data byte address.
- dtim_wdata  in  32: store data.
- dtim_wstrb  in  4: byte enables; 0 means load.
- dtim_gnt  out  1: data request accepted this cycle.
- dtim_rdata  out  32: load data.
- dtim_error  out  1: data response is an error.
- dtim_ready  out  1: data response valid.

## Operation
- Address decode, per port: off = addr − tim_base; bank = off[bw+1:2]; index = off[dw+bw+1:bw+2].
- Out of range: off ≥ tim_width*tim_depth*4.
  - Always granted; never touches a bank.
  - Response next cycle: ready=1, error=1, rdata=0.
  - A store to an out-of-range address is dropped.
- Each bank (tim_bank) does one access per cycle: a read, or a byte-enabled write. Bytes whose wstrb bit is 0 keep their stored value.
- Grant rules:
  - Both ports valid, in range, different banks: both granted.
  - Both ports valid, in range, same bank: conflict. The arbiter decides, and the loser gets gnt=0.
  - Single valid port: granted.
- Arbiter: one state bit, last_loser ∈ {IFETCH, DATA}; reset value DATA.
  - On a conflict, the data port wins unless last_loser=IFETCH, in which case fetch wins.
  - After each conflict, last_loser is set to the port that lost.
  - Non-conflict cycles leave last_loser unchanged.
  - Result: under sustained conflict the ports alternate, and no port waits more than 1 cycle.
- A requester whose gnt=0 holds valid/addr/wdata/wstrb stable until granted. A granted requester may present a new request the next cycle.
- Responses:
  - Load/fetch: rdata = word at index, as it stood after all writes accepted in earlier cycles.
  - Store: ready=1, rdata=0, error=0.
  - rdata=0 whenever ready=0.
- No forwarding is needed. A write accepted in cycle N is committed at edge N+1, and any read of the same word is accepted in cycle ≥N+1 (same-bank same-cycle accesses are serialised by arbitration).

## Timing
- Latency: request granted in cycle N; response (ready, rdata, error) asserted in cycle N+1 for exactly 1 cycle.
- Throughput: 1 request per port per cycle with no conflicts.
- gnt is combinational from valid and addr of both ports, plus last_loser.
- Bank read data is registered inside tim_bank. The response bank select and the ready/error/store flags are registered in tim_dp.
- Reset (async assert), all outputs: ready=0, error=0, rdata=0, last_loser=DATA.
  - Any response pending at reset is dropped; no ready appears after deassertion.
  - RAM contents are not cleared.
  - gnt is combinational and may be 1 during reset. Requests during reset are ignored; no write occurs and no response is produced.

## Structure
- Package tim_dp_wires: bw and dw localparams; tim_bank_in_type {en, wen, wstrb[3:0], addr[dw-1:0], wdata[31:0]}; tim_bank_out_type {rdata[31:0]}; vector typedefs [tim_width]; port_type enum {IFETCH, DATA}.
- Sub-module tim_bank: one instance per bank (generate loop).
  - Single-port synchronous RAM, tim_depth×32, with byte write enables.
  - Registered rdata, updated only when en=1 and wen=0.
- tim_dp contains: decode, conflict detect, arbiter, bank input muxing, response registers, output muxing.

## Test plan
- Parallel access: store 32'hDEADBEEF (wstrb=4'hF) to bank 1 index 5. Next cycle, fetch same word and load bank 2. Required: both granted, both ready next cycle, fetch rdata=32'hDEADBEEF.
- Byte strobes: store 32'h11223344 with wstrb=4'hF, then 32'hAA00BB00 with wstrb=4'b1010, then load the word. Required: rdata=32'hAA22BB44.
- Sustained conflict: both ports hit bank 0 every cycle for 6 cycles from reset. Required grant order D,I,D,I,D,I; each response exactly 1 cycle after its grant.
- Out of range, with tim_base=32'h1000_0000: store to tim_base + window size, then load that same address. Required: both responses error=1, rdata=0; no bank written (verify by in-range loads of all banks at index 0).
- Back-to-back: store then load of the same address on consecutive cycles. Required: the load returns the new data.
- Reset mid-operation: grant a load, assert reset before the response edge, release reset after 2 cycles. Required: ready, rdata and error all 0 throughout; last_loser=DATA (next conflict grants data); memory contents preserved.

Source files
------------

// File: rtl/tim_dp_pkg.sv
// Shared types for the dual-port banked TIM: bank request/response payloads and port identifiers.
package tim_dp_wires;

  localparam int unsigned n_banks    = 4;
  localparam int unsigned bank_words = 1024;
  localparam int unsigned bw         = $clog2(n_banks);
  localparam int unsigned dw         = $clog2(bank_words);

  typedef struct packed {
    logic          en;
    logic          wen;
    logic [3:0]    wstrb;
    logic [dw-1:0] addr;
    logic [31:0]   wdata;
  } tim_bank_in_type;

  typedef struct packed {
    logic [31:0] rdata;
  } tim_bank_out_type;

  typedef tim_bank_in_type  tim_bank_in_vector  [n_banks];
  typedef tim_bank_out_type tim_bank_out_vector [n_banks];

  typedef enum logic {
    IFETCH = 1'b0,
    DATA   = 1'b1
  } port_type;

endpackage

// File: rtl/tim_dp_bank.sv
// One TIM bank: single-port synchronous RAM with byte write enables and registered read data.
module tim_bank
  import tim_dp_wires::*;
#(
  parameter int unsigned tim_depth = bank_words
) (
  input  logic             clock,
  input  logic             reset,
  input  tim_bank_in_type  bank_in,
  output tim_bank_out_type bank_out
);

  logic [31:0] mem [tim_depth];

  // Byte lanes with a clear strobe keep their stored value.
  always_ff @(posedge clock) begin
    if (bank_in.en && bank_in.wen) begin
      for (int i = 0; i < 4; i++) begin
        if (bank_in.wstrb[i]) mem[bank_in.addr][8*i +: 8] <= bank_in.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_out.rdata <= '0;
    end else if (bank_in.en && !bank_in.wen) begin
      bank_out.rdata <= mem[bank_in.addr];
    end
  end

endmodule

// File: rtl/tim_dp.sv
// Dual-port banked TIM: fetch and load/store ports share banks, same-bank conflicts alternate winners.
module tim_dp
  import tim_dp_wires::*;
#(
  parameter int unsigned tim_width = n_banks,
  parameter int unsigned tim_depth = bank_words,
  parameter logic [31:0] tim_base  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        itim_valid,
  input  logic [31:0] itim_addr,
  output logic        itim_gnt,
  output logic [31:0] itim_rdata,
  output logic        itim_error,
  output logic        itim_ready,
  input  logic        dtim_valid,
  input  logic [31:0] dtim_addr,
  input  logic [31:0] dtim_wdata,
  input  logic [3:0]  dtim_wstrb,
  output logic        dtim_gnt,
  output logic [31:0] dtim_rdata,
  output logic        dtim_error,
  output logic        dtim_ready
);

  localparam int unsigned bwl = $clog2(tim_width);
  localparam int unsigned dwl = $clog2(tim_depth);
  localparam logic [32:0] win = 33'(tim_width) * 33'(tim_depth) * 33'd4;

  logic [31:0]    i_off, d_off;
  logic           i_oor, d_oor;
  logic [bwl-1:0] i_bank, d_bank;
  logic [dwl-1:0] i_idx, d_idx;
  logic           conflict, i_go, d_go;
  port_type       last_loser;

  logic           i_rsp_valid, i_rsp_err;
  logic           d_rsp_valid, d_rsp_err, d_rsp_store;
  logic [bwl-1:0] i_rsp_bank, d_rsp_bank;

  tim_bank_in_type  bank_in  [tim_width];
  tim_bank_out_type bank_out [tim_width];

  // Window-relative decode; anything past the window is answered with an error.
  assign i_off  = itim_addr - tim_base;
  assign d_off  = dtim_addr - tim_base;
  assign i_oor  = {1'b0, i_off} >= win;
  assign d_oor  = {1'b0, d_off} >= win;
  assign i_bank = i_off[bwl+1:2];
  assign d_bank = d_off[bwl+1:2];
  assign i_idx  = i_off[dwl+bwl+1:bwl+2];
  assign d_idx  = d_off[dwl+bwl+1:bwl+2];

  assign conflict = itim_valid & dtim_valid & ~i_oor & ~d_oor & (i_bank == d_bank);
  assign itim_gnt = itim_valid & (~conflict | (last_loser == IFETCH));
  assign dtim_gnt = dtim_valid & (~conflict | (last_loser == DATA));

  // Banks are only driven outside reset so requests seen during reset have no effect.
  assign i_go = itim_gnt & ~i_oor & reset;
  assign d_go = dtim_gnt & ~d_oor & reset;

  always_comb begin
    for (int b = 0; b < int'(tim_width); b++) begin
      bank_in[b] = '0;
      if (i_go && i_bank == bwl'(b)) begin
        bank_in[b].en   = 1'b1;
        bank_in[b].addr = dw'(i_idx);
      end else if (d_go && d_bank == bwl'(b)) begin
        bank_in[b].en    = 1'b1;
        bank_in[b].wen   = |dtim_wstrb;
        bank_in[b].wstrb = dtim_wstrb;
        bank_in[b].addr  = dw'(d_idx);
        bank_in[b].wdata = dtim_wdata;
      end
    end
  end

  for (genvar b = 0; b < tim_width; b++) begin : g_bank
    tim_bank #(.tim_depth(tim_depth)) u_bank (
      .clock    (clock),
      .reset    (reset),
      .bank_in  (bank_in[b]),
      .bank_out (bank_out[b])
    );
  end

  // Response tracking and the one-bit arbiter history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_rsp_valid <= 1'b0;
      i_rsp_err   <= 1'b0;
      i_rsp_bank  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_err   <= 1'b0;
      d_rsp_store <= 1'b0;
      d_rsp_bank  <= '0;
      last_loser  <= DATA;
    end else begin
      i_rsp_valid <= itim_gnt;
      i_rsp_err   <= itim_gnt & i_oor;
      i_rsp_bank  <= i_bank;
      d_rsp_valid <= dtim_gnt;
      d_rsp_err   <= dtim_gnt & d_oor;
      d_rsp_store <= dtim_gnt & (|dtim_wstrb);
      d_rsp_bank  <= d_bank;
      if (conflict) last_loser <= itim_gnt ? DATA : IFETCH;
    end
  end

  assign itim_ready = i_rsp_valid;
  assign itim_error = i_rsp_err;
  assign itim_rdata = (i_rsp_valid && !i_rsp_err) ? bank_out[i_rsp_bank].rdata : '0;
  assign dtim_ready = d_rsp_valid;
  assign dtim_error = d_rsp_err;
  assign dtim_rdata = (d_rsp_valid && !d_rsp_err && !d_rsp_store) ? bank_out[d_rsp_bank].rdata : '0;

endmodule

// File: tb/tb_tim_dp.sv
// Bench for tim_dp: flat word-addressed memory model with a one-bit fairness history.
module tb_tim_dp;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WIN  = 32'h0000_4000;
  localparam int          NB   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        itim_valid, dtim_valid;
  logic [31:0] itim_addr, dtim_addr, dtim_wdata;
  logic [3:0]  dtim_wstrb;
  logic        itim_gnt, itim_error, itim_ready;
  logic        dtim_gnt, dtim_error, dtim_ready;
  logic [31:0] itim_rdata, dtim_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [int];
  bit          ll_fetch;
  logic [34:0] obs_i, exp_i, obs_d, exp_d;

  tim_dp #(.tim_width(4), .tim_depth(1024), .tim_base(BASE)) dut (
    .clock(clock), .reset(reset),
    .itim_valid(itim_valid), .itim_addr(itim_addr), .itim_gnt(itim_gnt),
    .itim_rdata(itim_rdata), .itim_error(itim_error), .itim_ready(itim_ready),
    .dtim_valid(dtim_valid), .dtim_addr(dtim_addr), .dtim_wdata(dtim_wdata),
    .dtim_wstrb(dtim_wstrb), .dtim_gnt(dtim_gnt), .dtim_rdata(dtim_rdata),
    .dtim_error(dtim_error), .dtim_ready(dtim_ready)
  );

  always #5 clock = ~clock;

  function automatic bit oor(input logic [31:0] a);
    return (a - BASE) >= WIN;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic int bank_of(input logic [31:0] a);
    return word_of(a) % NB;
  endfunction

  function automatic logic [31:0] waddr(input int bank, input int idx);
    return BASE + 32'((idx * NB + bank) * 4);
  endfunction

  // One cycle: drive, sample grants mid-cycle, predict, then sample the response after the next edge.
  task automatic step(input logic iv, input logic [31:0] ia, input logic dv,
                      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
    bit conf, eig, edg;
    logic ig, dg;
    itim_valid = iv; itim_addr = ia;
    dtim_valid = dv; dtim_addr = da; dtim_wdata = wd; dtim_wstrb = ws;
    @(negedge clock);
    ig = itim_gnt; dg = dtim_gnt;
    conf = iv && dv && !oor(ia) && !oor(da) && (bank_of(ia) == bank_of(da));
    eig  = iv && (!conf || ll_fetch);
    edg  = dv && (!conf || !ll_fetch);
    exp_i = '0;
    exp_d = '0;
    if (eig) exp_i = {1'b1, 1'b1, 1'b0, 32'h0} | (oor(ia) ? {2'b00, 1'b1, 32'h0} : {3'b000, mem_m[word_of(ia)]});
    if (edg) begin
      if (oor(da))       exp_d = {1'b1, 1'b1, 1'b1, 32'h0};
      else if (ws != 0)  exp_d = {1'b1, 1'b1, 1'b0, 32'h0};
      else               exp_d = {1'b1, 1'b1, 1'b0, mem_m[word_of(da)]};
      if (!oor(da) && ws != 0) begin
        logic [31:0] v;
        v = mem_m.exists(word_of(da)) ? mem_m[word_of(da)] : 32'h0;
        for (int i = 0; i < 4; i++) if (ws[i]) v[8*i +: 8] = wd[8*i +: 8];
        mem_m[word_of(da)] = v;
      end
    end
    if (conf) ll_fetch = !eig;
    @(posedge clock); #1;
    obs_i = {ig, itim_ready, itim_error, itim_rdata};
    obs_d = {dg, dtim_ready, dtim_error, dtim_rdata};
  endtask

  task automatic idle_inputs();
    itim_valid = 0; itim_addr = 0; dtim_valid = 0; dtim_addr = 0; dtim_wdata = 0; dtim_wstrb = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    idle_inputs();
    ll_fetch = 0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    ll_fetch = 0;
    for (int c = 0; c < 3; c++) begin
      itim_valid = 1; itim_addr = waddr(c, 1);
      dtim_valid = 1; dtim_addr = waddr(c, 1); dtim_wdata = $urandom; dtim_wstrb = 4'hF;
      @(posedge clock); #1;
      checks++;
      if ({itim_ready, itim_error, itim_rdata, dtim_ready, dtim_error, dtim_rdata} !== 68'h0) begin
        errors++;
        $display("FAIL reset_outputs: got ir=%b ie=%b ird=%h dr=%b de=%b drd=%h want all zero",
                 itim_ready, itim_error, itim_rdata, dtim_ready, dtim_error, dtim_rdata);
      end
    end
    idle_inputs();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_fill();
    for (int b = 0; b < NB; b++) begin
      for (int x = 0; x < 8; x++) begin
        step(0, 0, 1, waddr(b, x), $urandom, 4'hF);
        checks++;
        if (obs_d !== exp_d) begin errors++; $display("FAIL fill_d: got %h want %h", obs_d, exp_d); end
        checks++;
        if (obs_i !== exp_i) begin errors++; $display("FAIL fill_i: got %h want %h", obs_i, exp_i); end
      end
    end
  endtask

  task automatic test_parallel();
    step(0, 0, 1, waddr(1, 5), 32'hDEADBEEF, 4'hF);
    checks++;
    if (obs_d !== exp_d) begin errors++; $display("FAIL par_store: got %h want %h", obs_d, exp_d); end
    step(1, waddr(1, 5), 1, waddr(2, 5), 0, 4'h0);
    checks++;
    if (obs_i !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL par_fetch: got %h want %h", obs_i, {3'b110, 32'hDEADBEEF});
    end
    checks++;
    if (obs_d !== exp_d || obs_d[34:33] !== 2'b11) begin
      errors++; $display("FAIL par_load: got %h want %h", obs_d, exp_d);
    end
  endtask

  task automatic test_strobes();
    step(0, 0, 1, waddr(3, 2), 32'h11223344, 4'hF);
    step(0, 0, 1, waddr(3, 2), 32'hAA00BB00, 4'b1010);
    step(0, 0, 1, waddr(3, 2), 0, 4'h0);
    checks++;
    if (obs_d !== {3'b110, 32'hAA22BB44}) begin
      errors++; $display("FAIL strobe_merge: got %h want %h", obs_d, {3'b110, 32'hAA22BB44});
    end
  endtask

  task automatic test_conflict();
    logic [31:0] ia, da;
    int ni, nd;
    pulse_reset();
    ni = 0; nd = 1;
    ia = waddr(0, 0); da = waddr(0, 1);
    for (int k = 0; k < 6; k++) begin
      step(1, ia, 1, da, 0, 4'h0);
      checks++;
      if (obs_d[34] !== 1'(k % 2 == 0) || obs_i[34] !== 1'(k % 2 == 1)) begin
        errors++; $display("FAIL conflict_order[%0d]: got ig=%b dg=%b want dg=%b", k, obs_i[34], obs_d[34], k % 2 == 0);
      end
      checks++;
      if (obs_i !== exp_i || obs_d !== exp_d) begin
        errors++; $display("FAIL conflict_rsp[%0d]: got %h/%h want %h/%h", k, obs_i, obs_d, exp_i, exp_d);
      end
      if (obs_i[34]) begin ni = (ni + 2) % 8; ia = waddr(0, ni); end
      if (obs_d[34]) begin nd = (nd + 2) % 8; da = waddr(0, nd); end
    end
  endtask

  task automatic test_oor();
    step(0, 0, 1, BASE + WIN, 32'hCAFEF00D, 4'hF);
    checks++;
    if (obs_d !== {3'b111, 32'h0}) begin errors++; $display("FAIL oor_store: got %h want %h", obs_d, {3'b111, 32'h0}); end
    step(1, BASE + WIN, 1, BASE + WIN, 0, 4'h0);
    checks++;
    if (obs_d !== {3'b111, 32'h0} || obs_i !== {3'b111, 32'h0}) begin
      errors++; $display("FAIL oor_load: got %h/%h want %h", obs_i, obs_d, {3'b111, 32'h0});
    end
    for (int b = 0; b < NB; b++) begin
      step(0, 0, 1, waddr(b, 0), 0, 4'h0);
      checks++;
      if (obs_d !== exp_d) begin errors++; $display("FAIL oor_untouched[%0d]: got %h want %h", b, obs_d, exp_d); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v, a;
      v = $urandom; a = waddr(k, 7 - k);
      step(0, 0, 1, a, v, 4'hF);
      step(0, 0, 1, a, 0, 4'h0);
      checks++;
      if (obs_d !== {3'b110, v}) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", k, obs_d, {3'b110, v}); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, waddr(2, 0), 1, waddr(2, 1), 0, 4'h0);
    itim_valid = 0;
    dtim_valid = 1; dtim_addr = waddr(1, 3); dtim_wstrb = 4'h0;
    @(negedge clock);
    checks++;
    if (dtim_gnt !== 1'b1) begin errors++; $display("FAIL mid_grant: got %b want 1", dtim_gnt); end
    reset = 1'b0;
    dtim_wdata = 32'hBADBAD00; dtim_wstrb = 4'hF; dtim_addr = waddr(1, 3);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin @(negedge clock); reset = 1'b1; idle_inputs(); end
      @(posedge clock); #1;
      checks++;
      if ({itim_ready, itim_error, itim_rdata, dtim_ready, dtim_error, dtim_rdata} !== 68'h0) begin
        errors++; $display("FAIL mid_quiet[%0d]: got dr=%b de=%b drd=%h ir=%b want zero", c, dtim_ready, dtim_error, dtim_rdata, itim_ready);
      end
    end
    ll_fetch = 0;
    step(1, waddr(0, 2), 1, waddr(0, 3), 0, 4'h0);
    checks++;
    if (obs_d[34] !== 1'b1 || obs_i[34] !== 1'b0) begin
      errors++; $display("FAIL mid_arb: got ig=%b dg=%b want ig=0 dg=1", obs_i[34], obs_d[34]);
    end
    step(0, 0, 1, waddr(1, 3), 0, 4'h0);
    checks++;
    if (obs_d !== exp_d) begin errors++; $display("FAIL mid_preserved: got %h want %h", obs_d, exp_d); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) return BASE + WIN + 32'($urandom_range(0, 255) * 4) + lo;
    return waddr($urandom_range(0, NB - 1), $urandom_range(0, 7)) + lo;
  endfunction

  task automatic test_random();
    logic piv, pdv;
    logic [31:0] pia, pda, pwd;
    logic [3:0] pws;
    bit need_i, need_d;
    int iw, dwt;
    need_i = 1; need_d = 1; iw = 0; dwt = 0;
    piv = 0; pdv = 0; pia = 0; pda = 0; pwd = 0; pws = 0;
    for (int k = 0; k < 400; k++) begin
      if (need_i) begin piv = ($urandom_range(0, 3) != 0); pia = rand_addr(); end
      if (need_d) begin
        pdv = ($urandom_range(0, 3) != 0); pda = rand_addr(); pwd = $urandom;
        pws = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      step(piv, pia, pdv, pda, pwd, pws);
      checks++;
      if (obs_i !== exp_i) begin errors++; $display("FAIL rand_i[%0d]: got %h want %h", k, obs_i, exp_i); end
      checks++;
      if (obs_d !== exp_d) begin errors++; $display("FAIL rand_d[%0d]: got %h want %h", k, obs_d, exp_d); end
      iw  = (piv && !obs_i[34]) ? iw + 1 : 0;
      dwt = (pdv && !obs_d[34]) ? dwt + 1 : 0;
      checks++;
      if (iw > 1 || dwt > 1) begin errors++; $display("FAIL rand_starve[%0d]: got waits %0d/%0d want <=1", k, iw, dwt); end
      need_i = !piv || obs_i[34];
      need_d = !pdv || obs_d[34];
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_parallel();
    test_strobes();
    test_conflict();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
